// File: rtl/dly_pkg.sv
// Shared constants and helpers for the programmable pulse-delay bank.
package dly_pkg;

  typedef enum logic {
    DLY_IGNORE = 1'b0,
    DLY_RETRIG = 1'b1
  } dly_mode_e;

  localparam int unsigned CLK_NS = 20;

  // Converts a nanosecond delay to clk cycles, rounding down but never below one cycle.
  function automatic int unsigned dly_cycles(input int unsigned ns);
    int unsigned q;
    q = ns / CLK_NS;
    return (q == 0) ? 1 : q;
  endfunction

endpackage

// File: rtl/dly_chan.sv
// One delay channel: run counter, shadowed target, busy level and sticky overrun.
module dly_chan
  import dly_pkg::*;
#(
  parameter int unsigned CW = 13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trig,
  input  logic          abort,
  input  logic          ovr_clr,
  input  logic [CW-1:0] cnt,
  input  logic          mode,
  output logic          p,
  output logic          l,
  output logic          ovr
);

  logic [CW-1:0] r;
  logic [CW-1:0] tgt;
  logic          pcyc;
  logic          armed;
  logic          accept;
  logic          ovr_set;

  // r is nonzero exactly while running; the p cycle is r reaching the shadowed target.
  always_comb begin
    pcyc    = (r != '0) && (r == tgt);
    armed   = trig && !abort && (cnt != '0);
    accept  = armed && (!l || pcyc || (mode == DLY_RETRIG));
    ovr_set = armed && l && !pcyc;
    p       = pcyc && !abort;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r   <= '0;
      tgt <= '0;
      l   <= 1'b0;
      ovr <= 1'b0;
    end else begin
      if (abort) begin
        r <= '0;
        l <= 1'b0;
      end else if (accept) begin
        r   <= {{(CW-1){1'b0}}, 1'b1};
        tgt <= cnt;
        l   <= 1'b1;
      end else if (pcyc) begin
        r <= '0;
        l <= 1'b0;
      end else if (r != '0) begin
        r <= r + 1'b1;
      end

      if (ovr_set) begin
        ovr <= 1'b1;
      end else if (ovr_clr) begin
        ovr <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dly_chan_bank.sv
// Bank of NCH run-time-programmable pulse delay channels with a shared config port.
module dly_chan_bank
  import dly_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned CW         = 13,
  parameter int unsigned DEF_CNT    = 5,
  parameter logic        DEF_RETRIG = 1'b0,
  localparam int unsigned CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] trig,
  input  logic [NCH-1:0] abort,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_cnt,
  input  logic           cfg_retrig,
  input  logic [NCH-1:0] ovr_clr,
  output logic [NCH-1:0] p,
  output logic [NCH-1:0] l,
  output logic [NCH-1:0] ovr
);

  logic [CW-1:0]  cnt_q [NCH];
  logic [NCH-1:0] mode_q;

  // Decoding by equality against each channel index drops cfg_ch values >= NCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= CW'(DEF_CNT);
      end
      mode_q <= {NCH{DEF_RETRIG}};
    end else if (cfg_we) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (cfg_ch == CHW'(i)) begin
          cnt_q[i]  <= cfg_cnt;
          mode_q[i] <= cfg_retrig;
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    dly_chan #(
      .CW(CW)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .trig   (trig[g]),
      .abort  (abort[g]),
      .ovr_clr(ovr_clr[g]),
      .cnt    (cnt_q[g]),
      .mode   (mode_q[g]),
      .p      (p[g]),
      .l      (l[g]),
      .ovr    (ovr[g])
    );
  end

endmodule

// File: doc/dly_chan_bank.md
Name: dly_chan_bank

Overview:
- Bank of NCH independent, run-time-programmable pulse delay channels. It generalises the fixed per-delay counter modules: one instance replaces many hard-wired delays.
- Each channel turns a single-cycle trigger into a single-cycle pulse after a programmed number of clk cycles. It also provides a busy level, a retrigger/ignore mode, an abort input and a sticky overrun flag.
- Sits between the timing-chain control logic and the pulse consumers in the processor core.

Parameters:
- NCH, 4, number of channels (1..16).
- CW, 13, counter/count width in bits; maximum delay is 2^CW-1 cycles.
- DEF_CNT, 5, reset value of every channel's programmed count (cycles).
- DEF_RETRIG, 0, reset value of every channel's mode bit (0 = ignore, 1 = retrigger).

Ports:
- clk  in  1  system clock (20 ns period)
- reset  in  1  asynchronous, active-high reset
- trig  in  NCH  per-channel start pulse, sampled on the rising clk edge
- abort  in  NCH  per-channel cancel
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  $clog2(NCH) (minimum 1)  channel selected by the write
- cfg_cnt  in  CW  delay in cycles for the selected channel
- cfg_retrig  in  1  mode for the selected channel
- ovr_clr  in  NCH  per-channel clear of the sticky overrun flag
- p  out  NCH  delayed pulse, one cycle wide
- l  out  NCH  channel busy level
- ovr  out  NCH  sticky overrun flag

Behaviour:
- Reset (async): all run counters r = 0, l = 0, ovr = 0; cnt = DEF_CNT and mode = DEF_RETRIG for every channel; p = 0.
- Config:
  - cfg_we at an edge writes cnt[cfg_ch] and mode[cfg_ch].
  - A cfg_ch value >= NCH is ignored.
  - Config is shadowed: target tgt[i] is loaded from cnt[i] when a trigger is accepted. A write during a run does not affect that run.
- Start:
  - Trigger accepted at edge k when trig[i] = 1, abort[i] = 0, cnt[i] != 0, and the channel is in one of these states: idle; busy with mode = 1; or in its p cycle.
  - On acceptance: r <= 1, tgt <= cnt, l <= 1.
- Run: while r != 0, r increments each edge.
- Output: p[i] = (r == tgt) & ~abort[i], combinational.
  - Consequence: for a trigger at edge k, p is high exactly in the cycle after edge k+N-1. For N = 1, that is the cycle right after edge k.
- Completion: at the edge where p was high, r <= 0 and l <= 0, unless a new trigger is accepted at that same edge. In that case the restart wins, l stays 1, and no gap appears.
- l: high from edge k through the p cycle inclusive, i.e. exactly N cycles.
- cnt = 0 disables the channel: trig is ignored, no p, no ovr.
- Busy triggers (trig while l = 1, not in the p cycle):
  - Mode 0: trigger ignored, run continues unchanged, ovr <= 1.
  - Mode 1: run restarts at r = 1 with the current cnt, ovr <= 1.
- A trigger in the p cycle is a clean restart in both modes; ovr is not set.
- Abort:
  - At the edge: r <= 0, l <= 0.
  - p is suppressed in the abort cycle.
  - Abort wins over a simultaneous trig, and no ovr is set.
  - Abort on an idle channel has no effect.
- ovr:
  - Cleared by ovr_clr[i].
  - If set and clear occur in the same cycle, set wins.
- Counter never wraps: tgt <= 2^CW-1 and the run ends at tgt.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Reset mid-run: all runs are dropped immediately with no p; config returns to its defaults.

Decomposition:
- Package dly_pkg:
  - Mode constants DLY_IGNORE = 0, DLY_RETRIG = 1.
  - Constant CLK_NS = 20.
  - Function dly_cycles(ns) = max(1, floor(ns/CLK_NS)). Examples: 45 ns -> 2, 115 ns -> 5, 450 ns -> 22, 5 us -> 250.
- Sub-module dly_chan:
  - Holds one channel's r, tgt, l, ovr and the accept/abort logic.
  - Takes cnt and mode as inputs.
- Top level: config register file, cfg_ch decode, and a generate loop of NCH dly_chan instances.

Test Plan:
- Basic delay: cnt[0] = 5, trig[0] at edge 10 -> p[0] high only in cycle after edge 14; l[0] high for cycles after edges 10..14; ovr[0] = 0.
- Minimum delay: cnt[1] = 1, trig at edge 3 -> p[1] in cycle after edge 3, l[1] high 1 cycle. Then cnt[1] = 0 and trig -> no p, l, or ovr.
- Ignore mode: mode 0, cnt = 10, trig at edges 0 and 4 -> single p after edge 9; ovr set after edge 4. Then ovr_clr together with a new busy trig -> ovr stays 1.
- Retrigger mode: mode 1, cnt = 10, trig at edges 0 and 4 -> single p after edge 13, none near edge 9; ovr = 1. Trig exactly in the p cycle -> next p 10 cycles later, l continuous, ovr not set.
- Abort and shadowing: cnt = 8, trig at edge 0, write cnt = 3 at edge 2 -> p after edge 7. Retrigger, then abort in the p cycle -> p = 0, l falls, trig together with abort ignored.
- Async reset mid-run on all 4 channels -> p, l, ovr = 0 immediately, no later p; cnt reads back as DEF_CNT behaviour (trig -> p 5 cycles later).
